mem_access_initiator: RTL and testbench

//   MEM-stage initiator for data memory. Turns the single-cycle MemRead/MemWrite/Address/WriteData

---
 rtl/mem_access_initiator.sv | 141 ++++++++++++++
 tb/tb_mem_access_initiator.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_initiator.sv
// MEM-stage data-memory initiator: converts a single-cycle load/store into a req/ready
// transaction, stalls the pipeline until it completes, and flags illegal or timed-out accesses.
module mem_access_initiator #(
  parameter int MEM_WORDS = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic        Err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  timer_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        err_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        access;
  logic        illegal;
  logic [31:0] word_idx;

  assign access   = MemRead | MemWrite;
  assign word_idx = {2'b00, Address[31:2]};
  assign illegal  = (MemRead & MemWrite) | (Address[1:0] != 2'b00) |
                    (word_idx >= 32'(MEM_WORDS));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (access && illegal) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (access) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            we_q    <= MemWrite;
            addr_q  <= word_idx;
            wdata_q <= WriteData;
            timer_q <= '0;
            err_q   <= 1'b0;
          end
        end
        ST_REQ: begin
          // Completion wins over timeout when both happen in the last allowed cycle.
          if (mem_ready && (we_q || mem_rvalid)) begin
            state_q <= ST_DONE;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            if (!we_q) rdata_q <= mem_rdata;
          end else if (timer_q == TIMER_LAST) begin
            state_q <= ST_DONE;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            timer_q <= timer_q + 8'd1;
            if (mem_ready) begin
              state_q <= ST_WAIT;
              req_q   <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= mem_rdata;
          end else if (timer_q == TIMER_LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          err_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Stall       = ((state_q == ST_IDLE) && access) || (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign ReadData    = rdata_q;
  assign Done        = done_q;
  assign Err         = err_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed + randomized bench for mem_access_initiator with a model data memory and
// an expected-result queue ({Err, ReadData}) checked on every Done pulse.
module tb_mem_access_initiator;

  localparam int MEM_WORDS = 8;
  localparam int TIMEOUT   = 15;
  localparam int NEVER     = 1000;

  logic        clock;
  logic        reset_n;
  logic        MemRead, MemWrite;
  logic [31:0] Address, WriteData;
  logic [31:0] ReadData;
  logic        Stall, Done, Err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  logic [31:0] model_mem [MEM_WORDS];
  logic [32:0] exp_q[$];
  logic [31:0] exp_rd;
  int          n_checks;
  int          n_fails;

  mem_access_initiator #(.MEM_WORDS(MEM_WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .Done(Done), .Err(Err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One access: drives the request, plays the memory side, and checks the result.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int ready_dly, input int rvalid_dly);
    logic        illegal, timeout, got;
    int          idx, exp_stall, exp_reqc, stall_c, req_c, acc_at;
    logic [32:0] exp, obs;
    illegal = (rd & wr) | (addr[1:0] != 2'b00) | ((addr >> 2) >= 32'(MEM_WORDS));
    idx     = illegal ? 0 : int'(addr >> 2);
    timeout = !illegal && ((ready_dly + (rd ? rvalid_dly : 0)) >= TIMEOUT);
    if (illegal) begin
      exp_rd = '0; exp = {1'b1, 32'h0}; exp_stall = 1; exp_reqc = 0;
    end else if (timeout) begin
      exp_rd = '0; exp = {1'b1, 32'h0}; exp_stall = 1 + TIMEOUT;
      exp_reqc = (ready_dly < TIMEOUT) ? ready_dly + 1 : TIMEOUT;
    end else if (wr) begin
      model_mem[idx] = wdata;
      exp = {1'b0, exp_rd}; exp_stall = ready_dly + 2; exp_reqc = ready_dly + 1;
    end else begin
      exp_rd = model_mem[idx];
      exp = {1'b0, exp_rd}; exp_stall = ready_dly + rvalid_dly + 2; exp_reqc = ready_dly + 1;
    end
    exp_q.push_back(exp);

    @(posedge clock); #1;
    MemRead = rd; MemWrite = wr; Address = addr; WriteData = wdata;
    stall_c = 0; req_c = 0; acc_at = -1; got = 1'b0; obs = '0;
    for (int cyc = 0; cyc < 200 && !got; cyc++) begin
      mem_ready = mem_req && (req_c >= ready_dly);
      if (mem_ready && acc_at < 0) acc_at = cyc;
      mem_rvalid = rd && !wr && (acc_at >= 0) && (cyc - acc_at == rvalid_dly);
      mem_rdata  = mem_rvalid ? model_mem[idx] : 32'h0;
      @(negedge clock);
      if (Stall) stall_c++;
      if (mem_req) begin
        if (req_c == 0) begin
          check({tag, ":mem_we"}, mem_we, wr);
          check({tag, ":mem_addr"}, mem_addr, addr >> 2);
          if (wr) check({tag, ":mem_wdata"}, mem_wdata, wdata);
        end
        req_c++;
      end
      if (Done) begin
        got = 1'b1;
        obs = {Err, ReadData};
      end else begin
        @(posedge clock); #1;
      end
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    check({tag, ":done_seen"}, got, 1'b1);
    if (got && exp_q.size() > 0) check({tag, ":err_rdata"}, obs, exp_q.pop_front());
    check({tag, ":stall_cycles"}, stall_c, exp_stall);
    check({tag, ":req_cycles"}, req_c, exp_reqc);
  endtask

  // Idle cycles with no access; memory-side inputs may be driven to prove they are ignored.
  task automatic idle_cycles(input string tag, input int n, input logic rvalid, input logic [31:0] rdata);
    @(posedge clock); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_ready = rvalid; mem_rvalid = rvalid; mem_rdata = rdata;
      @(negedge clock);
      check({tag, ":done_idle"}, {Done, Stall, mem_req}, 3'b000);
      if (i != n - 1) begin @(posedge clock); #1; end
    end
    check({tag, ":rdata_held"}, ReadData, exp_rd);
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    n_checks = 0; n_fails = 0; exp_rd = '0;
    for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = $urandom;
    MemRead = 0; MemWrite = 0; Address = '0; WriteData = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    reset_n = 1'b0;
    #3;
    check("reset:outputs", {ReadData, Done, Err, mem_req, mem_we, mem_addr, mem_wdata, Stall}, '0);
    check("reset:state", dbg_state, 2'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    run_access("t1_write", 1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 0, 0);
    idle_cycles("t1_idle", 1, 1'b0, 32'h0);

    model_mem[7] = 32'h12345678;
    run_access("t2_read", 1'b1, 1'b0, 32'h1C, 32'h0, 0, 3);
    idle_cycles("t2_hold", 2, 1'b0, 32'h0);

    run_access("t3_misaligned", 1'b1, 1'b0, 32'h6, 32'h0, 0, 0);
    run_access("t3_range", 1'b0, 1'b1, 32'h20, 32'h55AA55AA, 0, 0);
    run_access("t3_rdwr", 1'b1, 1'b1, 32'h4, 32'h1, 0, 0);
    idle_cycles("t3_idle", 1, 1'b0, 32'h0);

    run_access("t4_preload", 1'b1, 1'b0, 32'h1C, 32'h0, 1, 0);
    run_access("t4_timeout", 1'b1, 1'b0, 32'h4, 32'h0, NEVER, 0);
    idle_cycles("t4_late_rvalid", 3, 1'b1, 32'hFFFFFFFF);

    run_access("t6_store", 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 1, 0);
    run_access("t6_load", 1'b1, 1'b0, 32'h10, 32'h0, 0, 1);
    check("t6_value", exp_rd, 32'hCAFEF00D);

    for (int k = 0; k < 6; k++) begin
      logic [31:0] a;
      logic        w;
      a = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
      w = 1'($urandom_range(0, 1));
      run_access("rand", !w, w, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    idle_cycles("rand_idle", 1, 1'b0, 32'h0);

    // Reset while a read sits in WAIT.
    @(posedge clock); #1;
    MemRead = 1'b1; Address = 32'hC;
    @(posedge clock); #1;
    mem_ready = 1'b1;
    @(posedge clock); #1;
    mem_ready = 1'b0;
    @(negedge clock);
    check("t5_in_wait", {dbg_state, Stall, mem_req}, {2'd2, 1'b1, 1'b0});
    #2;
    reset_n = 1'b0; MemRead = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5;
    #1;
    check("t5_async_outputs", {ReadData, Done, Err, mem_req, mem_we, mem_addr, mem_wdata, Stall}, '0);
    check("t5_async_state", dbg_state, 2'd0);
    @(negedge clock);
    reset_n = 1'b1;
    exp_rd = '0;
    @(negedge clock);
    check("t5_rvalid_ignored", {ReadData, Done, dbg_state}, '0);
    mem_rvalid = 1'b0; mem_rdata = '0;
    run_access("t5_fresh_read", 1'b1, 1'b0, 32'h0, 32'h0, 0, 0);
    idle_cycles("t5_idle", 1, 1'b0, 32'h0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
